image_loader: RTL and testbench

- Avalon-MM master that drains an RS232 UART core, byte by byte, into SRAM.
- Packs BYTES_PER_WORD received bytes, MSB-first, into one SRAM_DW-bit word and issues one single-cycle SRAM write per word.
- Start/restart/abort capable, with configurable byte count and base address.
- Sits between the UART core and the SRAM arbiter; feeds the frame buffer before image processing starts.

---
 rtl/image_loader_pkg.sv | 13 +
 rtl/image_loader_if.sv | 14 +
 rtl/image_loader_byte_packer.sv | 53 +++++
 rtl/image_loader.sv | 103 ++++++++++
 tb/tb_image_loader.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/image_loader_pkg.sv
// image_loader_pkg: FSM states and UART register map shared by the image loader
package image_loader_pkg;

    typedef enum logic [2:0] {IDLE, POLL, READ, WRITE, DONE} state_t;

    localparam logic [4:0] RX_BASE     = 5'd0;
    localparam logic [4:0] TX_BASE     = 5'd4;
    localparam logic [4:0] STATUS_BASE = 5'd8;

    localparam int RX_OK_BIT = 7;
    localparam int TX_OK_BIT = 6;

endpackage

// File: rtl/image_loader_if.sv
// image_loader_if: Avalon-MM bus between the image loader and the UART core
interface image_loader_if;

    logic [4:0]  address;
    logic        read;
    logic [31:0] readdata;
    logic        write;
    logic [31:0] writedata;
    logic        waitrequest;

    modport master (output address, read, write, writedata, input readdata, waitrequest);
    modport slave  (input address, read, write, writedata, output readdata, waitrequest);

endinterface

// File: rtl/image_loader_byte_packer.sv
// byte_packer: packs bytes MSB-first into a DW-bit word, left-justifying a partial word
module byte_packer #(
    parameter int DW = 16
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_clear,
    input  logic          i_shift,
    input  logic [7:0]    i_byte,
    output logic          o_last_lane,
    output logic [DW-1:0] o_word
);

    localparam int BPW = DW / 8;
    localparam int LW  = $clog2(BPW + 1);

    logic [DW-1:0] pack_q, pack_d, shift_word;
    logic [LW-1:0] lanes_q, lanes_d;

    if (DW == 8) begin : g_single
        assign shift_word = i_byte;
    end else begin : g_multi
        assign shift_word = {pack_q[DW-9:0], i_byte};
    end

    // clear wins over shift so a word boundary and a restart never mix bytes
    always_comb begin
        pack_d  = pack_q;
        lanes_d = lanes_q;
        if (i_clear) begin
            pack_d  = '0;
            lanes_d = '0;
        end else if (i_shift) begin
            pack_d  = shift_word;
            lanes_d = lanes_q + LW'(1);
        end
    end

    // pack register and lane count
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pack_q  <= '0;
            lanes_q <= '0;
        end else begin
            pack_q  <= pack_d;
            lanes_q <= lanes_d;
        end
    end

    assign o_last_lane = lanes_q == LW'(BPW - 1);
    assign o_word      = pack_q << (8 * (BPW - int'(lanes_q)));

endmodule

// File: rtl/image_loader.sv
// image_loader: drains a UART over Avalon-MM and writes the packed bytes into SRAM
module image_loader
    import image_loader_pkg::*;
#(
    parameter int          TOTAL_BYTES = 460800,
    parameter int          SRAM_AW     = 20,
    parameter int          SRAM_DW     = 16,
    parameter int unsigned BASE_ADDR   = 0,
    parameter int          CNT_W       = 19
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic               i_abort,
    image_loader_if.master     avm,
    output logic               o_sram_we,
    output logic [SRAM_AW-1:0] o_sram_addr,
    output logic [SRAM_DW-1:0] o_sram_data,
    output logic               o_busy,
    output logic               o_finished,
    output logic [CNT_W-1:0]   o_byte_cnt
);

    state_t             state_q, state_d;
    logic               read_q, read_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SRAM_AW-1:0] addr_q, addr_d;
    logic               xfer, go, last_lane, last_byte, all_bytes, shift, clear;
    logic [SRAM_DW-1:0] word;
    logic               unused_rd;

    assign xfer      = avm.read && !avm.waitrequest;
    assign go        = i_start && !i_abort && (state_q == IDLE || state_q == DONE);
    assign last_byte = cnt_q == CNT_W'(TOTAL_BYTES - 1);
    assign all_bytes = cnt_q == CNT_W'(TOTAL_BYTES);
    assign shift     = state_q == READ && xfer && !i_abort;
    assign clear     = go || i_abort || state_q == WRITE;
    assign unused_rd = ^avm.readdata[31:8];

    byte_packer #(.DW(SRAM_DW)) u_packer (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_clear     (clear),
        .i_shift     (shift),
        .i_byte      (avm.readdata[7:0]),
        .o_last_lane (last_lane),
        .o_word      (word)
    );

    // state and datapath registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            read_q  <= 1'b0;
            cnt_q   <= '0;
            addr_q  <= SRAM_AW'(BASE_ADDR);
        end else begin
            state_q <= state_d;
            read_q  <= read_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
        end
    end

    // next state; abort overrides every transition
    always_comb begin
        state_d = state_q;
        if (i_abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: state_d = i_start ? POLL : state_q;
                POLL:       state_d = (xfer && avm.readdata[RX_OK_BIT]) ? READ : POLL;
                READ:       state_d = xfer ? ((last_lane || last_byte) ? WRITE : POLL) : READ;
                WRITE:      state_d = all_bytes ? DONE : POLL;
                default:    state_d = IDLE;
            endcase
        end
    end

    // read is low on state entry and after each completion, giving a one-cycle gap
    always_comb begin
        read_d = (state_q == POLL || state_q == READ) && !i_abort && !xfer;
        cnt_d  = go ? '0 : shift ? cnt_q + CNT_W'(1) : cnt_q;
        addr_d = go ? SRAM_AW'(BASE_ADDR) : (state_q == WRITE) ? addr_q + SRAM_AW'(1) : addr_q;
    end

    // Moore outputs decoded from the current state
    always_comb begin
        o_sram_we   = state_q == WRITE;
        o_sram_data = o_sram_we ? word : '0;
        o_busy      = state_q == POLL || state_q == READ || state_q == WRITE;
        o_finished  = state_q == DONE;
        avm.address = (state_q == READ) ? RX_BASE : STATUS_BASE;
    end

    assign avm.read      = read_q;
    assign avm.write     = 1'b0;
    assign avm.writedata = '0;
    assign o_sram_addr   = addr_q;
    assign o_byte_cnt    = cnt_q;

endmodule

// File: tb/tb_image_loader.sv
// tb_image_loader: randomized UART/stall stimulus checked against a byte-list reference model
module tb_image_loader;
    import image_loader_pkg::*;

    localparam int          TOTAL = 5;
    localparam int          DW    = 16;
    localparam int          BPW   = DW / 8;
    localparam int          AW    = 20;
    localparam int unsigned BASE  = 32'hFFFFE;

    logic          clk, rst_n, start, abort;
    logic          sram_we, busy, finished;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_data;
    logic [3:0]    byte_cnt;

    image_loader_if avm();

    image_loader #(
        .TOTAL_BYTES (TOTAL),
        .SRAM_AW     (AW),
        .SRAM_DW     (DW),
        .BASE_ADDR   (BASE),
        .CNT_W       (4)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_abort     (abort),
        .avm         (avm),
        .o_sram_we   (sram_we),
        .o_sram_addr (sram_addr),
        .o_sram_data (sram_data),
        .o_busy      (busy),
        .o_finished  (finished),
        .o_byte_cnt  (byte_cnt)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    bit          stall_en = 0;
    int          poll_left = 2;
    bit          prev_stall = 0;
    logic [4:0]  prev_addr = '0;
    logic [7:0]  sent[$];
    logic [31:0] gaddr[$];
    logic [31:0] gdata[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // one clock: UART slave model, Avalon hold check and SRAM write capture
    task automatic tick();
        logic [31:0] rd;
        @(negedge clk);
        if (rst_n && !abort && prev_stall) begin
            check("hold_addr", 32'(avm.address), 32'(prev_addr));
            check("hold_read", 32'(avm.read), 32'd1);
        end
        avm.waitrequest = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
        rd = $urandom;
        if (avm.address == STATUS_BASE) rd[RX_OK_BIT] = (poll_left == 0);
        avm.readdata = rd;
        if (rst_n && avm.read && !avm.waitrequest) begin
            if (avm.address == STATUS_BASE) begin
                if (poll_left > 0) poll_left--;
            end else if (avm.address == RX_BASE) begin
                sent.push_back(rd[7:0]);
                poll_left = $urandom_range(0, 3);
            end
        end
        prev_stall = rst_n && avm.read && avm.waitrequest;
        prev_addr  = avm.address;
        if (sram_we) begin
            gaddr.push_back(32'(sram_addr));
            gdata.push_back(32'(sram_data));
        end
    endtask

    task automatic clear_model();
        sent.delete();
        gaddr.delete();
        gdata.delete();
    endtask

    // expected writes: accepted bytes grouped MSB-first, last word zero-padded, address wraps
    task automatic compare_writes(input string tag);
        int          n, nw, idx;
        logic [31:0] word, ea;
        n  = sent.size();
        nw = (n + BPW - 1) / BPW;
        check({tag, "_nbytes"}, 32'(n), 32'(TOTAL));
        check({tag, "_nwrites"}, 32'(gaddr.size()), 32'(nw));
        for (int w = 0; w < nw && w < gaddr.size(); w++) begin
            word = '0;
            for (int l = 0; l < BPW; l++) begin
                idx  = w * BPW + l;
                word = (word << 8) | ((idx < n) ? 32'(sent[idx]) : 32'd0);
            end
            ea = (BASE + 32'(w)) & ((32'd1 << AW) - 1);
            check({tag, "_addr"}, gaddr[w], ea);
            check({tag, "_data"}, gdata[w], word);
        end
    endtask

    task automatic run_load(input string tag);
        clear_model();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 4000 && !finished; c++) begin
            tick();
            if (c == 7 && busy && !sram_we) begin
                start = 1'b1;
                tick();
                start = 1'b0;
            end
        end
        check({tag, "_finished"}, 32'(finished), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_cnt"}, 32'(byte_cnt), 32'(TOTAL));
        compare_writes(tag);
    endtask

    initial begin
        bit any_act;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        avm.waitrequest = 1'b0;
        avm.readdata = '0;
        repeat (3) tick();
        check("rst_read", 32'(avm.read), 32'd0);
        check("rst_address", 32'(avm.address), 32'(STATUS_BASE));
        check("rst_sram_addr", 32'(sram_addr), BASE);
        check("rst_cnt", 32'(byte_cnt), 32'd0);
        rst_n = 1'b1;
        any_act = 1'b0;
        for (int c = 0; c < 50; c++) begin
            tick();
            any_act |= avm.read | sram_we | finished | busy;
        end
        check("idle_activity", 32'(any_act), 32'd0);
        check("idle_sram_addr", 32'(sram_addr), BASE);
        check("idle_write", 32'(avm.write), 32'd0);

        stall_en = 1'b0;
        run_load("plain");
        stall_en = 1'b1;
        repeat (13) run_load("stall");

        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        tick();
        check("both_finished", 32'(finished), 32'd0);
        check("both_busy", 32'(busy), 32'd0);
        repeat (5) tick();
        check("both_stays_idle", 32'(busy), 32'd0);

        clear_model();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 4000 && byte_cnt != 4'd3; c++) tick();
        check("abort_reached", 32'(byte_cnt), 32'd3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_read", 32'(avm.read), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        repeat (10) tick();
        check("abort_writes", 32'(gaddr.size()), 32'd1);
        check("abort_finished", 32'(finished), 32'd0);
        run_load("reload");

        clear_model();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 4000 && !sram_we; c++) tick();
        check("rw_we_seen", 32'(sram_we), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rw_we", 32'(sram_we), 32'd0);
        check("rw_cnt", 32'(byte_cnt), 32'd0);
        check("rw_addr", 32'(sram_addr), BASE);
        check("rw_data", 32'(sram_data), 32'd0);
        check("rw_busy", 32'(busy), 32'd0);
        check("rw_read", 32'(avm.read), 32'd0);
        tick();
        rst_n = 1'b1;
        run_load("after_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
